// File: rtl/cfg_pkg.sv
// Shared types and default sizing for the LE configuration-chain loader.
package cfg_pkg;

   // Bits per logic element: one MODE bit followed by a 16-entry LUT.
   localparam int LE_CFG_BITS = 17;
   // Width of the incoming bitstream word.
   localparam int CFG_WORD_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } cfg_state_t;

endpackage

// File: rtl/cfg_chain_ctrl.sv
// Serialises bitstream words, MSB first, into a daisy-chained LE config chain.
// Words are fetched on demand; the chain only shifts while bits are available,
// so gaps in word_valid simply hold the chain in place.
module cfg_chain_ctrl
   import cfg_pkg::*;
#(
   parameter int CHAIN_LEN = LE_CFG_BITS,
   parameter int WORD_W    = CFG_WORD_W
)(
   input  logic              clk,
   input  logic              nrst,
   input  logic              start,
   input  logic              abort,
   input  logic              word_valid,
   input  logic [WORD_W-1:0] word_data,
   output logic              word_ready,
   output logic              cfg_en,
   output logic              cfg_data,
   output logic              fabric_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BC_W = $clog2(CHAIN_LEN + 1);
   localparam int WC_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(CHAIN_LEN - 1);
   localparam logic [WC_W-1:0] WBIT_LAST = WC_W'(WORD_W - 1);

   cfg_state_t        state, state_nxt;
   logic [WORD_W-1:0] sreg;
   logic [BC_W-1:0]   bit_cnt;
   logic [WC_W-1:0]   word_bit_cnt;
   logic              err_q;
   logic              aborting;

   // Abort only counts while a load is actually in flight.
   assign aborting = abort && (state != IDLE);
   assign err      = err_q;

   // State register.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic; abort overrides every other transition.
   always_comb begin
      state_nxt = state;
      if (aborting) begin
         state_nxt = IDLE;
      end else begin
         unique case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: if (word_valid) state_nxt = SHIFT;
            SHIFT: begin
               // Last chain bit wins over end-of-word: leftover word bits are dropped.
               if (bit_cnt == BIT_LAST)            state_nxt = DONE;
               else if (word_bit_cnt == WBIT_LAST) state_nxt = FETCH;
            end
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Moore outputs decoded from the current state.
   always_comb begin
      word_ready = (state == FETCH);
      cfg_en     = (state == SHIFT);
      cfg_data   = (state == SHIFT) && sreg[WORD_W-1];
      busy       = (state != IDLE);
      done       = (state == DONE);
   end

   // Datapath: word register, bit counters, fabric enable and error pulse.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sreg         <= '0;
         bit_cnt      <= '0;
         word_bit_cnt <= '0;
         fabric_en    <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         err_q <= aborting;
         if (aborting) begin
            fabric_en <= 1'b0;
         end else begin
            unique case (state)
               IDLE: if (start) begin
                  fabric_en    <= 1'b0;
                  bit_cnt      <= '0;
                  word_bit_cnt <= '0;
               end
               FETCH: if (word_valid) sreg <= word_data;
               SHIFT: begin
                  sreg         <= sreg << 1;
                  bit_cnt      <= bit_cnt + 1'b1;
                  word_bit_cnt <= (word_bit_cnt == WBIT_LAST) ? '0 : word_bit_cnt + 1'b1;
               end
               DONE: fabric_en <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Randomised scoreboard bench: one loader driving a single LE and one loader
// driving a four-LE chain; the LE chains are modelled as shift registers.
module tb_cfg_chain_ctrl;
   import cfg_pkg::*;

   localparam int CL0 = LE_CFG_BITS;
   localparam int CL1 = 4 * LE_CFG_BITS;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic [1:0] start = '0, abort = '0, word_valid = '0;
   logic [7:0] word_data [2];
   logic [1:0] word_ready, cfg_en, cfg_data, fabric_en, busy, done, err;

   int n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   cfg_chain_ctrl u_dut0 (
      .clk(clk), .nrst(nrst), .start(start[0]), .abort(abort[0]),
      .word_valid(word_valid[0]), .word_data(word_data[0]),
      .word_ready(word_ready[0]), .cfg_en(cfg_en[0]), .cfg_data(cfg_data[0]),
      .fabric_en(fabric_en[0]), .busy(busy[0]), .done(done[0]), .err(err[0]));

   cfg_chain_ctrl #(.CHAIN_LEN(CL1), .WORD_W(8)) u_dut1 (
      .clk(clk), .nrst(nrst), .start(start[1]), .abort(abort[1]),
      .word_valid(word_valid[1]), .word_data(word_data[1]),
      .word_ready(word_ready[1]), .cfg_en(cfg_en[1]), .cfg_data(cfg_data[1]),
      .fabric_en(fabric_en[1]), .busy(busy[1]), .done(done[1]), .err(err[1]));

   // LE config registers: g_le[0] is the lone LE of dut0, g_le[1..4] the chain of dut1.
   for (genvar j = 0; j < 5; j++) begin : g_le
      logic        din, en;
      logic [16:0] cfg = '0;
      if (j == 0) begin : g_a
         assign en = cfg_en[0]; assign din = cfg_data[0];
      end else if (j == 1) begin : g_b
         assign en = cfg_en[1]; assign din = cfg_data[1];
      end else begin : g_c
         assign en = cfg_en[1]; assign din = g_le[j-1].cfg[16];
      end
      // Config shift: first bit in ends up in the MODE position of the last LE.
      always @(posedge clk) if (en) cfg <= {cfg[15:0], din};
   end

   logic [16:0] chain0;
   logic [67:0] chain1;
   assign chain0 = g_le[0].cfg;
   assign chain1 = {g_le[4].cfg, g_le[3].cfg, g_le[2].cfg, g_le[1].cfg};

   // LE behaviour for dut0: LUT4 lookup, registered when MODE=1.
   logic [3:0]  le_sel = '0;
   logic [15:0] lut0;
   logic        le_dff, le_out;
   assign lut0   = g_le[0].cfg[15:0];
   assign le_out = g_le[0].cfg[16] ? le_dff : lut0[le_sel];
   always @(posedge clk or negedge nrst)
      if (!nrst) le_dff <= 1'b0; else if (fabric_en[0]) le_dff <= lut0[le_sel];

   typedef struct {
      bit          is_err;
      logic [67:0] chain;
      int          ncfg;
      int          nhs;
   } exp_t;
   exp_t sb0[$], sb1[$];

   logic [7:0] wbuf [16];

   task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: the chain holds the first cl stream bits, first bit at the far end.
   function automatic logic [67:0] ref_chain(input int cl);
      logic [67:0] r;
      logic [7:0]  w;
      r = '0;
      for (int b = 0; b < cl; b++) begin
         w = wbuf[b / 8];
         r[cl - 1 - b] = w[7 - (b % 8)];
      end
      return r;
   endfunction

   task automatic fill_rand(input int n);
      for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
   endtask

   // Monitor: count shift cycles and handshakes, check each done/err against the scoreboard.
   int ncfg [2];
   int nhs  [2];
   always @(negedge clk) begin : mon
      exp_t e;
      bit   have;
      if (!nrst) begin
         ncfg[0] = 0; ncfg[1] = 0; nhs[0] = 0; nhs[1] = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (cfg_en[i]) ncfg[i]++;
            if (word_valid[i] && word_ready[i]) nhs[i]++;
            if (done[i] || err[i]) begin
               have = (i == 0) ? (sb0.size() > 0) : (sb1.size() > 0);
               if (!have) begin
                  n_chk++; n_fail++;
                  $display("FAIL sb_unexpected inst %0d: done=%0b err=%0b with nothing expected", i, done[i], err[i]);
               end else begin
                  if (i == 0) e = sb0.pop_front(); else e = sb1.pop_front();
                  chk("sb_kind_err", 68'(err[i]), 68'(e.is_err));
                  if (!e.is_err) begin
                     chk("sb_cfg_en_cycles", 68'(ncfg[i]), 68'(e.ncfg));
                     chk("sb_word_handshakes", 68'(nhs[i]), 68'(e.nhs));
                     chk("sb_chain", (i == 0) ? {51'b0, chain0} : chain1, e.chain);
                  end
               end
               ncfg[i] = 0; nhs[i] = 0;
            end
         end
      end
   end

   // One load on instance i using wbuf; abort_bit>=0 aborts on that shift bit.
   task automatic do_load(input int i, input int nw, input int gap, input int abort_bit, input bit poke);
      int   w = 0, g = 0, bits = 0, cyc = 0;
      bit   fin = 0;
      int   cl;
      exp_t e;
      cl       = (i == 0) ? CL0 : CL1;
      e.is_err = (abort_bit >= 0);
      e.chain  = ref_chain(cl);
      e.ncfg   = cl;
      e.nhs    = (cl + 7) / 8;
      if (i == 0) sb0.push_back(e); else sb1.push_back(e);
      @(posedge clk); #1 start[i] = 1'b1;
      @(posedge clk); #1 start[i] = 1'b0;
      chk("busy_after_start", 68'(busy[i]), 68'd1);
      chk("fabric_cleared_on_start", 68'(fabric_en[i]), 68'd0);
      while (!fin && cyc < 800) begin
         if (done[i] || err[i]) begin
            fin = 1;
         end else begin
            word_valid[i] = (g == 0) && (w < nw);
            word_data[i]  = (word_valid[i] && word_ready[i]) ? wbuf[w] : 8'($urandom);
            if (word_valid[i] && word_ready[i]) begin
               w++; g = gap;
            end else if (word_ready[i] && g > 0) begin
               chk("gap_chain_holds", 68'(cfg_en[i]), 68'd0);
               g--;
            end
            abort[i] = (abort_bit >= 0) && cfg_en[i] && (bits == abort_bit);
            start[i] = poke && cfg_en[i] && (bits == 5);
            if (cfg_en[i]) bits++;
            cyc++;
            @(posedge clk); #1;
         end
      end
      abort[i] = 1'b0; start[i] = 1'b0; word_valid[i] = 1'b0;
      if (!fin) begin
         n_chk++; n_fail++;
         $display("FAIL load_timeout inst %0d: no done/err after %0d cycles", i, cyc);
      end else if (e.is_err) begin
         chk("abort_busy", 68'(busy[i]), 68'd0);
         chk("abort_fabric", 68'(fabric_en[i]), 68'd0);
         chk("abort_word_ready", 68'(word_ready[i]), 68'd0);
         chk("abort_shift_bit", 68'(bits), 68'(abort_bit + 1));
         @(posedge clk); #1;
         chk("err_one_cycle", 68'(err[i]), 68'd0);
      end else begin
         chk("done_no_shift", 68'(cfg_en[i]), 68'd0);
         @(posedge clk); #1;
         chk("done_one_cycle", 68'(done[i]), 68'd0);
         chk("fabric_set", 68'(fabric_en[i]), 68'd1);
         chk("idle_after_done", 68'(busy[i]), 68'd0);
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int cyc;
      word_data[0] = '0; word_data[1] = '0;
      #12;
      chk("reset_outputs", 68'({word_ready, cfg_en, cfg_data, fabric_en, busy, done, err}), 68'd0);
      @(posedge clk); #1 nrst = 1'b1;
      @(posedge clk); #1;

      // Single-LE load, back-to-back words.
      wbuf[0] = 8'h80; wbuf[1] = 8'h00; wbuf[2] = 8'h80;
      do_load(0, 3, 0, -1, 0);
      chk("s39_fabric_holds", 68'(fabric_en[0]), 68'd1);

      // MODE=1, LUT=0: registered output path selected.
      wbuf[0] = 8'h80; wbuf[1] = 8'h00; wbuf[2] = 8'h00;
      do_load(0, 3, 0, -1, 0);
      chk("s40_mode", 68'(g_le[0].cfg[16]), 68'd1);
      chk("s40_lut", 68'(lut0), 68'd0);
      le_sel = 4'hF;
      repeat (2) @(posedge clk);
      #1 chk("s40_le_out", 68'(le_out), 68'd0);

      // Gaps of 5 cycles between words.
      fill_rand(3);
      do_load(0, 3, 5, -1, 0);

      // Abort on shift bit 10, then a clean reload.
      fill_rand(3);
      do_load(0, 3, 0, 10, 0);
      fill_rand(3);
      do_load(0, 3, 0, -1, 0);

      // start pulsed mid-shift is ignored.
      fill_rand(3);
      do_load(0, 3, 0, -1, 1);

      // Random loads with random gaps.
      for (int n = 0; n < 4; n++) begin
         fill_rand(3);
         do_load(0, 3, int'($urandom_range(0, 3)), -1, 0);
      end

      // Reset while fetching word 2: everything drops asynchronously, no err.
      fill_rand(3);
      @(posedge clk); #1 start[0] = 1'b1;
      @(posedge clk); #1 start[0] = 1'b0; word_valid[0] = 1'b1; word_data[0] = wbuf[0];
      @(posedge clk); #1 word_valid[0] = 1'b0;
      cyc = 0;
      while (!word_ready[0] && cyc < 30) begin @(posedge clk); #1; cyc++; end
      chk("rst_reached_fetch2", 68'(word_ready[0]), 68'd1);
      nrst = 1'b0;
      #1 chk("rst_async_outputs", 68'({word_ready, cfg_en, cfg_data, fabric_en, busy, done, err}), 68'd0);
      @(posedge clk); #1 nrst = 1'b1;
      @(posedge clk); #1;

      // Four-LE chain: 9 words, 68 shift cycles.
      fill_rand(9);
      do_load(1, 9, 0, -1, 0);
      fill_rand(9);
      do_load(1, 9, int'($urandom_range(1, 4)), -1, 0);

      repeat (3) @(posedge clk);
      #1 chk("sb_drained", 68'(sb0.size() + sb1.size()), 68'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
